// File: rtl/npu_pkg.sv
// Shared definitions for the NPU layer controllers and engines.
// Holds the scheduler state encoding, the error-code values reported on
// err_code, the conv1 geometry shared with the engine, and a helper that
// derives the watchdog limit from that geometry.
package npu_pkg;

  // conv1 geometry, shared with the conv1 engine
  localparam int CONV1_CHAN   = 10;
  localparam int CONV1_OUT1_H = 14;
  localparam int CONV1_OUT1_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IMG,
    RUN,
    DRAIN,
    ERR,
    FLUSH
  } sched_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVR  = 2'd1;
  localparam logic [1:0] ERR_SEQ  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // One channel takes out_h*out_w cycles plus one; the watchdog tolerates
  // that period, the slack, and one more cycle before declaring a stall.
  function automatic int wdog_limit(input int out_h, input int out_w, input int slack);
    return out_h * out_w + 1 + slack + 1;
  endfunction

endpackage

// File: rtl/sched_wdog.sv
// Watchdog counter for the conv1 scheduler.
// Loadable up-counter that saturates at LIMIT.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (highest priority)
//   en         : count one cycle
//   load       : load load_val into the count
//   load_val   : value for load
//   expire     : high in the cycle whose edge brings the count to LIMIT
module sched_wdog #(
  parameter int LIMIT = 192,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != LIM) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Flagged one cycle early so the owner changes state on the very edge
  // at which the count reaches LIMIT.
  assign expire = en && !clr && !load && (cnt == LIM_M1);

endmodule

// File: rtl/conv1_sched.sv
// conv1 layer controller.
// Starts a frame once the input image is stable and the engine is idle,
// keeps the image locked while the CHAN channel passes run, hands each
// finished channel to the consumer via chan_req/chan_ack, and reports
// overrun, sequence and timeout faults.
//   start         : frame start request (IDLE only)
//   abort         : cancel the frame or clear an error
//   img_valid     : input image loaded and stable
//   img_lock      : image must not be modified while high
//   eng_trigger   : one-cycle engine trigger
//   eng_out_valid : engine channel-complete pulse, with eng_out_chan
//   chan_req      : channel buffer chan_id ready for consumer
//   chan_ack      : consumer has copied the buffer
//   busy          : not in IDLE
//   done          : one-cycle pulse on clean frame completion
//   err, err_code : sticky error flag and cause
//   frame_cnt     : completed frames, wrapping
module conv1_sched
  import npu_pkg::*;
#(
  parameter int CHAN       = npu_pkg::CONV1_CHAN,
  parameter int OUT1_H     = npu_pkg::CONV1_OUT1_H,
  parameter int OUT1_W     = npu_pkg::CONV1_OUT1_W,
  parameter int WDOG_SLACK = 8,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              img_valid,
  output logic              img_lock,
  output logic              eng_trigger,
  input  logic              eng_out_valid,
  input  logic [3:0]        eng_out_chan,
  output logic              chan_req,
  output logic [3:0]        chan_id,
  input  logic              chan_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int         LIMIT     = wdog_limit(OUT1_H, OUT1_W, WDOG_SLACK);
  localparam int         WD_W      = $clog2(LIMIT + 1);
  localparam logic [3:0] LAST_CHAN = 4'(CHAN - 1);

  sched_state_t state, state_nxt;

  logic       eng_idle;
  logic [3:0] exp_chan;

  // events decoded by the next-state logic
  logic       trig;
  logic       accept;
  logic [1:0] fault_code;
  logic       finish;
  logic       idle_set;
  logic       cancel;

  logic match;
  logic last_seen;
  logic ack_hs;
  logic wd_en;
  logic wd_clr;
  logic wd_expire;

  assign match     = eng_out_valid && (eng_out_chan == exp_chan);
  assign last_seen = eng_out_valid && (eng_out_chan == LAST_CHAN);
  assign ack_hs    = chan_req && chan_ack;

  // The watchdog only runs while the engine is expected to be producing
  // channels; any channel pulse restarts the period.
  assign wd_en  = (state == RUN) || (state == FLUSH);
  assign wd_clr = eng_out_valid || !wd_en;

  sched_wdog #(
    .LIMIT (LIMIT),
    .CNT_W (WD_W)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .en       (wd_en),
    .load     (1'b0),
    .load_val ('0),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    trig       = 1'b0;
    accept     = 1'b0;
    fault_code = ERR_NONE;
    finish     = 1'b0;
    idle_set   = 1'b0;
    cancel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!abort && start) state_nxt = WAIT_IMG;
      end
      WAIT_IMG: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (img_valid && eng_idle) begin
          trig      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Seeing the last channel means the engine has stopped, whatever
        // else happens in this cycle.
        idle_set = last_seen;
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = (eng_idle || last_seen) ? IDLE : FLUSH;
        end else if (eng_out_valid && !match) begin
          fault_code = ERR_SEQ;
          state_nxt  = ERR;
        end else if (match && chan_req && !chan_ack) begin
          fault_code = ERR_OVR;
          state_nxt  = ERR;
        end else if (match) begin
          accept = 1'b1;
          if (exp_chan == LAST_CHAN) state_nxt = DRAIN;
        end else if (wd_expire) begin
          fault_code = ERR_TMO;
          state_nxt  = ERR;
        end
      end
      DRAIN: begin
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = eng_idle ? IDLE : FLUSH;
        end else if (ack_hs) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        idle_set = last_seen;
        if (abort) begin
          cancel    = 1'b1;
          state_nxt = (eng_idle || last_seen) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        // Wait for the engine to finish the channels it is still running
        // so a new trigger never lands on a busy engine.
        if (last_seen || wd_expire) begin
          idle_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_idle    <= 1'b1;
      exp_chan    <= '0;
      img_lock    <= 1'b0;
      eng_trigger <= 1'b0;
      chan_req    <= 1'b0;
      chan_id     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      frame_cnt   <= '0;
    end else begin
      eng_trigger <= trig;
      done        <= finish;
      if (trig) begin
        img_lock <= 1'b1;
        eng_idle <= 1'b0;
        exp_chan <= '0;
      end
      if (idle_set) eng_idle <= 1'b1;
      // A new channel may replace one being acked in the same cycle.
      if (accept) begin
        chan_req <= 1'b1;
        chan_id  <= exp_chan;
        exp_chan <= exp_chan + 4'd1;
      end else if (ack_hs) begin
        chan_req <= 1'b0;
      end
      if (fault_code != ERR_NONE) begin
        err      <= 1'b1;
        err_code <= fault_code;
        chan_req <= 1'b0;
        img_lock <= 1'b0;
      end
      if (cancel) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
        chan_req <= 1'b0;
        img_lock <= 1'b0;
      end
      if (finish) begin
        img_lock  <= 1'b0;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv1_sched.sv
// Directed bench for conv1_sched with a cycle-stepped engine model and an
// acking consumer. Channels the engine produces that the scheduler should
// hand over are queued and matched against each rising chan_req.
module tb_conv1_sched;

  localparam int CH = 10;
  localparam int P  = 14 * 13 + 1;
  localparam int L  = P + 8 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        img_valid = 1'b0;
  logic        eng_out_valid = 1'b0;
  logic [3:0]  eng_out_chan = 4'd0;
  logic        chan_ack = 1'b0;
  logic        img_lock, eng_trigger, chan_req, busy, done, err;
  logic [3:0]  chan_id;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int trig_cnt, done_cnt, req_cnt, extra_req, lock_gap;
  int in_frame;
  int prev_req = 0, prev_err = 0, prev_busy = 0;
  int err_rise_cyc = 0, idle_cyc = 0, last_pulse_cyc = 0;
  int ack_cnt = 0, hold_chan = -1;
  int eng_on = 0, eng_timer = 0, eng_next = 0, last_drv = -1;
  int stall_after = -1, skip_chan = -1, push_max = 9;
  int sb[$];

  conv1_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .img_valid     (img_valid),
    .img_lock      (img_lock),
    .eng_trigger   (eng_trigger),
    .eng_out_valid (eng_out_valid),
    .eng_out_chan  (eng_out_chan),
    .chan_req      (chan_req),
    .chan_id       (chan_id),
    .chan_ack      (chan_ack),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_code      (err_code),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_counts();
    trig_cnt = 0; done_cnt = 0; req_cnt = 0; extra_req = 0; lock_gap = 0;
    in_frame = 0; last_drv = -1; hold_chan = -1; skip_chan = -1;
    stall_after = -1; push_max = 9;
  endtask

  // One clock: sample outputs after the edge, then let the consumer and
  // engine models drive their inputs for the next cycle.
  task automatic cycle();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin done_cnt++; in_frame = 0; end
    if (in_frame != 0 && !img_lock) lock_gap++;
    if (eng_trigger) begin trig_cnt++; in_frame = 1; end
    if (err && prev_err == 0) err_rise_cyc = cyc;
    if (!busy && prev_busy != 0) idle_cyc = cyc;
    prev_err = int'(err);
    prev_busy = int'(busy);

    if (chan_req && prev_req == 0) begin
      req_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("chan_id", 32'(chan_id), e);
      end else begin
        extra_req++;
      end
      if (int'(chan_id) != hold_chan) ack_cnt = 2;
    end
    prev_req = int'(chan_req);
    chan_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) chan_ack = 1'b1;
    end

    eng_out_valid = 1'b0;
    if (eng_trigger) begin
      eng_on = 1; eng_timer = P; eng_next = 0;
    end else if (eng_on != 0) begin
      eng_timer--;
      if (eng_timer == 0) begin
        eng_out_valid = 1'b1;
        eng_out_chan = 4'(eng_next);
        last_pulse_cyc = cyc;
        last_drv = eng_next;
        if (eng_next <= push_max) sb.push_back(eng_next);
        if (eng_next == stall_after || eng_next == CH - 1) eng_on = 0;
        eng_next++;
        if (eng_next == skip_chan) eng_next++;
        eng_timer = P;
      end
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin cycle(); n++; end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic run_err(input string tag, input int budget);
    int n = 0;
    while (!err && n < budget) begin cycle(); n++; end
    chk(tag, 32'(err), 1);
  endtask

  initial begin
    int n;
    int abort_cyc;
    reset_counts();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_img_lock", 32'(img_lock), 0);
    chk("rst_eng_trigger", 32'(eng_trigger), 0);
    chk("rst_chan_req", 32'(chan_req), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'({err, err_code}), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    cycle();

    // clean frame
    reset_counts();
    img_valid = 1'b1; start = 1'b1; cycle(); start = 1'b0;
    run_idle("t1_idle", 3000);
    chk("t1_trig_cnt", trig_cnt, 1);
    chk("t1_req_cnt", req_cnt, 10);
    chk("t1_extra_req", extra_req, 0);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_lock_gap", lock_gap, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_err", 32'(err), 0);

    // image not yet valid
    reset_counts();
    img_valid = 1'b0; start = 1'b1; cycle(); start = 1'b0;
    repeat (50) cycle();
    chk("t2_no_trig", trig_cnt, 0);
    chk("t2_busy", 32'(busy), 1);
    img_valid = 1'b1; cycle();
    chk("t2_trig_next", 32'(eng_trigger), 1);
    run_idle("t2_idle", 3000);
    chk("t2_frame_cnt", 32'(frame_cnt), 2);

    // overrun: channel 3 unacked when channel 4 arrives
    reset_counts();
    hold_chan = 3; push_max = 3;
    start = 1'b1; cycle(); start = 1'b0;
    run_err("t3_err", 3000);
    chk("t3_err_code", 32'(err_code), 1);
    chk("t3_at_ch4", last_drv, 4);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("t3_flush_busy", 32'(busy), 1);
    chk("t3_err_cleared", 32'({err, err_code}), 0);
    chk("t3_req_lock_low", 32'({chan_req, img_lock}), 0);
    run_idle("t3_flush_idle", 3000);
    chk("t3_exit_on_ch9", idle_cyc - last_pulse_cyc, 1);
    chk("t3_last_drv", last_drv, 9);
    chk("t3_sb_empty", sb.size(), 0);
    reset_counts();
    start = 1'b1; cycle(); start = 1'b0;
    run_idle("t3_next_idle", 3000);
    chk("t3_next_trig", trig_cnt, 1);
    chk("t3_next_done", done_cnt, 1);
    chk("t3_frame_cnt", 32'(frame_cnt), 3);

    // sequence error: chan 2 where chan 1 is expected
    reset_counts();
    skip_chan = 1; hold_chan = 0; push_max = 0;
    start = 1'b1; cycle(); start = 1'b0;
    run_err("t4_err", 1000);
    chk("t4_err_code", 32'(err_code), 2);
    chk("t4_req_drop", 32'(chan_req), 0);
    abort = 1'b1; cycle(); abort = 1'b0;
    run_idle("t4_idle", 3000);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_frame_cnt", 32'(frame_cnt), 3);

    // timeout: engine stalls after channel 0
    reset_counts();
    stall_after = 0; push_max = 0;
    start = 1'b1; cycle(); start = 1'b0;
    run_err("t5_err", 1000);
    chk("t5_err_code", 32'(err_code), 3);
    chk("t5_tmo_latency", err_rise_cyc - last_pulse_cyc - 1, L);
    abort_cyc = cyc;
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("t5_flush_busy", 32'(busy), 1);
    run_idle("t5_idle", 500);
    chk("t5_flush_wdog_exit", idle_cyc - abort_cyc - 1, L);

    // abort at channel 4, start during FLUSH ignored
    reset_counts();
    push_max = 3;
    start = 1'b1; cycle(); start = 1'b0;
    n = 0;
    while (last_drv != 4 && n < 2000) begin cycle(); n++; end
    chk("t6_reach_ch4", last_drv, 4);
    abort = 1'b1; cycle(); abort = 1'b0;
    chk("t6_flush_busy", 32'(busy), 1);
    chk("t6_flags_low", 32'({err, chan_req, img_lock}), 0);
    trig_cnt = 0;
    start = 1'b1; cycle(); start = 1'b0;
    run_idle("t6_idle", 3000);
    chk("t6_exit_on_ch9", idle_cyc - last_pulse_cyc, 1);
    repeat (3) cycle();
    chk("t6_no_trig", trig_cnt, 0);
    chk("t6_start_ignored", 32'(busy), 0);
    chk("t6_sb_empty", sb.size(), 0);

    // asynchronous reset mid-RUN
    reset_counts();
    start = 1'b1; cycle(); start = 1'b0;
    n = 0;
    while (req_cnt < 2 && n < 2000) begin cycle(); n++; end
    chk("t7_in_run", 32'({busy, chan_req}), 3);
    rst_n = 1'b0;
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_req_lock", 32'({chan_req, img_lock}), 0);
    chk("t7_chan_id", 32'(chan_id), 0);
    chk("t7_frame_cnt", 32'(frame_cnt), 0);
    chk("t7_err", 32'({err, err_code, done, eng_trigger}), 0);
    eng_on = 0; ack_cnt = 0; sb.delete();
    eng_out_valid = 1'b0; chan_ack = 1'b0;
    prev_req = 0; prev_busy = 0; prev_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    reset_counts();
    start = 1'b1; cycle(); start = 1'b0;
    run_idle("t7_recover_idle", 3000);
    chk("t7_recover_done", done_cnt, 1);
    chk("t7_recover_frame_cnt", 32'(frame_cnt), 1);
    chk("t7_recover_sb", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
